// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences TLB maintenance instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL,
// INVTLB) onto the ports of the tlb block and owns the fill-index policy. Search port 1
// is shared with the load/store path; TLBSRCH/INVTLB borrow it for their EXEC cycle.
//
// Build option: define TLB_FILL_LFSR_EN to pick fill entries from an 8-bit LFSR instead
// of the default round-robin counter.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   op_valid/op_ready/op_code       instruction handshake and opcode
//   inv_op/inv_asid/inv_vppn        INVTLB operands
//   csr_asid/csr_vppn/csr_index/csr_ne  CSR operands (ASID, TLBEHI, TLBIDX)
//   mem_vppn/mem_asid/mem_req       load/store lookup request on port 1
//   mem_stall                       port 1 borrowed this cycle
//   s1_vppn/s1_asid, s1_found/s1_index  tlb search port 1
//   r_index, r_e                    tlb read port
//   we/w_index/w_e                  tlb write port
//   invtlb_valid/invtlb_op          tlb invalidate port
//   done/op_err                     completion pulse and INE flag
//   res_found/res_index/res_ne      held TLBSRCH / TLBRD results
module tlb_op_ctrl #(
   parameter int unsigned TLBNUM = 16,
   localparam int unsigned IW = $clog2(TLBNUM)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          op_valid,
   output logic          op_ready,
   input  logic [2:0]    op_code,
   input  logic [4:0]    inv_op,
   input  logic [9:0]    inv_asid,
   input  logic [18:0]   inv_vppn,
   input  logic [9:0]    csr_asid,
   input  logic [18:0]   csr_vppn,
   input  logic [IW-1:0] csr_index,
   input  logic          csr_ne,
   input  logic [18:0]   mem_vppn,
   input  logic [9:0]    mem_asid,
   input  logic          mem_req,
   output logic          mem_stall,
   output logic [18:0]   s1_vppn,
   output logic [9:0]    s1_asid,
   input  logic          s1_found,
   input  logic [IW-1:0] s1_index,
   output logic [IW-1:0] r_index,
   input  logic          r_e,
   output logic          we,
   output logic [IW-1:0] w_index,
   output logic          w_e,
   output logic          invtlb_valid,
   output logic [4:0]    invtlb_op,
   output logic          done,
   output logic          op_err,
   output logic          res_found,
   output logic [IW-1:0] res_index,
   output logic          res_ne
);

   localparam logic [2:0] OpSrch = 3'd0;
   localparam logic [2:0] OpRd   = 3'd1;
   localparam logic [2:0] OpWr   = 3'd2;
   localparam logic [2:0] OpFill = 3'd3;
   localparam logic [2:0] OpInv  = 3'd4;

   typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

   state_e        state_q;
   logic [2:0]    op_q;
   logic          err_q;
   logic [4:0]    inv_op_q;
   logic [9:0]    inv_asid_q;
   logic [18:0]   inv_vppn_q;
   logic [9:0]    csr_asid_q;
   logic [18:0]   csr_vppn_q;
   logic [IW-1:0] csr_index_q;
   logic          csr_ne_q;
   logic          res_found_q;
   logic [IW-1:0] res_index_q;
   logic          res_ne_q;
   logic [IW-1:0] fill_idx;

   logic exec, is_srch, is_rd, is_wr, is_fill, inv_ok, port_take;

   // Strobes are gated with reset so an aborted op never touches the TLB.
   assign exec      = (state_q == StExec) && !reset;
   assign is_srch   = (op_q == OpSrch);
   assign is_rd     = (op_q == OpRd);
   assign is_wr     = (op_q == OpWr);
   assign is_fill   = (op_q == OpFill);
   assign inv_ok    = (op_q == OpInv) && !err_q;
   assign port_take = exec && (is_srch || inv_ok);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         op_q        <= OpSrch;
         err_q       <= 1'b0;
         inv_op_q    <= '0;
         inv_asid_q  <= '0;
         inv_vppn_q  <= '0;
         csr_asid_q  <= '0;
         csr_vppn_q  <= '0;
         csr_index_q <= '0;
         csr_ne_q    <= 1'b0;
         res_found_q <= 1'b0;
         res_index_q <= '0;
         res_ne_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (op_valid) begin
                  state_q     <= StExec;
                  op_q        <= op_code;
                  err_q       <= (op_code > OpInv) || ((op_code == OpInv) && (inv_op > 5'd6));
                  inv_op_q    <= inv_op;
                  inv_asid_q  <= inv_asid;
                  inv_vppn_q  <= inv_vppn;
                  csr_asid_q  <= csr_asid;
                  csr_vppn_q  <= csr_vppn;
                  csr_index_q <= csr_index;
                  csr_ne_q    <= csr_ne;
               end
            end
            StExec: begin
               state_q <= StDone;
               // tlb lookups are combinational, so results are captured at the end of EXEC.
               if (is_srch) begin
                  res_found_q <= s1_found;
                  res_index_q <= s1_index;
               end
               if (is_rd) res_ne_q <= ~r_e;
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef TLB_FILL_LFSR_EN
   // Fibonacci LFSR, taps 8,6,5,4; free-running for pseudo-random replacement.
   logic [7:0] lfsr_q;
   always_ff @(posedge clk) begin
      if (reset) lfsr_q <= 8'h01;
      else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end
   assign fill_idx = lfsr_q[IW-1:0];
`else
   // Round-robin; power-of-two TLBNUM makes the natural overflow the wrap.
   logic [IW-1:0] fill_q;
   always_ff @(posedge clk) begin
      if (reset)                fill_q <= '0;
      else if (exec && is_fill) fill_q <= fill_q + 1'b1;
   end
   assign fill_idx = fill_q;
`endif

   always_comb begin
      op_ready     = (state_q == StIdle) && !reset;
      done         = (state_q == StDone) && !reset;
      op_err       = done && err_q;
      we           = exec && (is_wr || is_fill);
      w_index      = '0;
      if (exec && is_fill)    w_index = fill_idx;
      else if (exec && is_wr) w_index = csr_index_q;
      w_e          = we ? ~csr_ne_q : 1'b0;
      r_index      = (exec && is_rd) ? csr_index_q : '0;
      invtlb_valid = exec && inv_ok;
      invtlb_op    = invtlb_valid ? inv_op_q : 5'd0;
      mem_stall    = mem_req && port_take;
      s1_vppn      = mem_vppn;
      s1_asid      = mem_asid;
      if (port_take && is_srch) begin
         s1_vppn = csr_vppn_q;
         s1_asid = csr_asid_q;
      end else if (port_take) begin
         s1_vppn = inv_vppn_q;
         s1_asid = inv_asid_q;
      end
      res_found    = res_found_q;
      res_index    = res_index_q;
      res_ne       = res_ne_q;
   end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
module tb_tlb_op_ctrl;
   localparam int unsigned TLBNUM = 16;
   localparam int unsigned IW = 4;

   logic clk, reset, op_valid, op_ready, csr_ne, mem_req, mem_stall, s1_found, r_e;
   logic we, w_e, invtlb_valid, done, op_err, res_found, res_ne;
   logic [2:0] op_code;
   logic [4:0] inv_op, invtlb_op;
   logic [9:0] inv_asid, csr_asid, mem_asid, s1_asid;
   logic [18:0] inv_vppn, csr_vppn, mem_vppn, s1_vppn;
   logic [IW-1:0] csr_index, s1_index, r_index, w_index, res_index;

   tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
      .op_code(op_code), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
      .csr_asid(csr_asid), .csr_vppn(csr_vppn), .csr_index(csr_index), .csr_ne(csr_ne),
      .mem_vppn(mem_vppn), .mem_asid(mem_asid), .mem_req(mem_req), .mem_stall(mem_stall),
      .s1_vppn(s1_vppn), .s1_asid(s1_asid), .s1_found(s1_found), .s1_index(s1_index),
      .r_index(r_index), .r_e(r_e), .we(we), .w_index(w_index), .w_e(w_e),
      .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op), .done(done), .op_err(op_err),
      .res_found(res_found), .res_index(res_index), .res_ne(res_ne)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Minimal tlb environment model: entries written with the values the bench issued.
   logic [TLBNUM-1:0] ent_e = '0;
   logic [18:0] ent_vppn [TLBNUM];
   logic [9:0]  ent_asid [TLBNUM];
   logic [18:0] m_wvppn;
   logic [9:0]  m_wasid;

   always @(posedge clk) begin
      if (we) begin
         ent_e[w_index]    <= w_e;
         ent_vppn[w_index] <= m_wvppn;
         ent_asid[w_index] <= m_wasid;
      end
      if (invtlb_valid) ent_e <= '0;
   end

   always_comb begin
      s1_found = 1'b0;
      s1_index = '0;
      for (int i = 0; i < TLBNUM; i++) begin
         if (ent_e[i] && ent_vppn[i] == s1_vppn && ent_asid[i] == s1_asid) begin
            s1_found = 1'b1;
            s1_index = IW'(i);
         end
      end
   end
   assign r_e = ent_e[r_index];

   // Reference LFSR for the optional fill policy.
   logic [7:0] m_lfsr;
   always @(posedge clk) begin
      if (reset) m_lfsr <= 8'h01;
      else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   int n_tests = 0;
   int n_fail  = 0;
   logic [IW-1:0] fill_cnt;

   localparam logic [18:0] MemVppn = 19'h5A5A5;
   localparam logic [9:0]  MemAsid = 10'h3C3;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [IW-1:0] exp_fill();
`ifdef TLB_FILL_LFSR_EN
      return m_lfsr[IW-1:0];
`else
      return fill_cnt;
`endif
   endfunction

   typedef struct {
      logic [2:0]  op;
      logic [4:0]  inv_op;
      logic [3:0]  idx;
      logic        ne;
      logic [18:0] vppn;
      logic        mreq;
      logic        e_we;
      logic [3:0]  e_widx;
      logic        e_wbit;
      logic        e_inv;
      logic        e_stall;
      logic        e_err;
      logic        e_found;
      logic [3:0]  e_ridx;
      logic        e_ne;
   } vec_t;

   vec_t vecs [11];

   task automatic wait_ready();
      int w = 0;
      while (!op_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!op_ready) begin
         chk("ready_timeout", 32'(op_ready), 32'd1);
         $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
         $fatal(1, "op_ready never rose");
      end
   endtask

   task automatic do_op(input vec_t v, input int n);
      logic [18:0] e_s1;
      logic [3:0]  e_widx;
      @(negedge clk);
      wait_ready();
      op_valid  = 1'b1;
      op_code   = v.op;
      inv_op    = v.inv_op;
      inv_vppn  = v.vppn ^ 19'h40000;
      inv_asid  = 10'h2AA;
      csr_vppn  = v.vppn;
      csr_asid  = 10'h011;
      csr_index = v.idx;
      csr_ne    = v.ne;
      mem_req   = v.mreq;
      m_wvppn   = v.vppn;
      m_wasid   = 10'h011;
      @(negedge clk);
      // EXEC: operands changed here must be ignored.
      op_valid  = 1'b0;
      op_code   = 3'd1;
      inv_op    = 5'd2;
      csr_index = ~v.idx;
      csr_ne    = ~v.ne;
      csr_vppn  = ~v.vppn;
      #1;
      e_widx = (v.op == 3'd3) ? exp_fill() : v.e_widx;
      chk($sformatf("v%0d exec we", n), 32'(we), 32'(v.e_we));
      chk($sformatf("v%0d exec w_index", n), 32'(w_index), 32'(e_widx));
      chk($sformatf("v%0d exec w_e", n), 32'(w_e), 32'(v.e_wbit));
      chk($sformatf("v%0d exec invtlb_valid", n), 32'(invtlb_valid), 32'(v.e_inv));
      chk($sformatf("v%0d exec invtlb_op", n), 32'(invtlb_op), v.e_inv ? 32'(v.inv_op) : 32'd0);
      chk($sformatf("v%0d exec mem_stall", n), 32'(mem_stall), 32'(v.e_stall));
      chk($sformatf("v%0d exec busy", n), {30'd0, op_ready, done}, 32'd0);
      if (!v.e_err) begin
         if (v.op == 3'd0)  e_s1 = v.vppn;
         else if (v.e_inv)  e_s1 = v.vppn ^ 19'h40000;
         else               e_s1 = MemVppn;
         chk($sformatf("v%0d exec s1_vppn", n), 32'(s1_vppn), 32'(e_s1));
      end
      if (v.op == 3'd3) fill_cnt = fill_cnt + 1'b1;
      @(negedge clk);
      #1;
      chk($sformatf("v%0d done", n), 32'(done), 32'd1);
      chk($sformatf("v%0d op_err", n), 32'(op_err), 32'(v.e_err));
      chk($sformatf("v%0d done strobes", n), {30'd0, we, invtlb_valid}, 32'd0);
      chk($sformatf("v%0d res_found", n), 32'(res_found), 32'(v.e_found));
      chk($sformatf("v%0d res_index", n), 32'(res_index), 32'(v.e_ridx));
      chk($sformatf("v%0d res_ne", n), 32'(res_ne), 32'(v.e_ne));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int wcount;
      vec_t fv;
      //            op  inv    idx ne vppn     mreq we widx wb inv stl err fnd ridx ne
      vecs[0]  = '{3'd2, 5'd0, 4'd5, 1'b0, 19'h12345, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
      vecs[1]  = '{3'd0, 5'd0, 4'd0, 1'b0, 19'h12345, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0};
      vecs[2]  = '{3'd2, 5'd0, 4'd3, 1'b1, 19'h00333, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0};
      vecs[3]  = '{3'd1, 5'd0, 4'd3, 1'b0, 19'h00000, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b1};
      vecs[4]  = '{3'd1, 5'd0, 4'd5, 1'b0, 19'h00000, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0};
      vecs[5]  = '{3'd0, 5'd0, 4'd0, 1'b0, 19'h00999, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
      vecs[6]  = '{3'd4, 5'd5, 4'd0, 1'b0, 19'h00777, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
      vecs[7]  = '{3'd0, 5'd0, 4'd0, 1'b0, 19'h12345, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
      vecs[8]  = '{3'd4, 5'd9, 4'd0, 1'b0, 19'h00777, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
      vecs[9]  = '{3'd6, 5'd0, 4'd0, 1'b0, 19'h00000, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
      vecs[10] = '{3'd3, 5'd0, 4'd0, 1'b0, 19'h0AAAA, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};

      reset = 1'b1; op_valid = 1'b0; op_code = '0; inv_op = '0; inv_asid = '0; inv_vppn = '0;
      csr_asid = '0; csr_vppn = '0; csr_index = '0; csr_ne = 1'b0;
      mem_vppn = MemVppn; mem_asid = MemAsid; mem_req = 1'b1;
      m_wvppn = '0; m_wasid = '0; fill_cnt = '0;

      // Reset state.
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst op_ready", 32'(op_ready), 32'd0);
      chk("rst strobes", {28'd0, we, invtlb_valid, done, mem_stall}, 32'd0);
      chk("rst s1_vppn", 32'(s1_vppn), 32'(MemVppn));
      chk("rst s1_asid", 32'(s1_asid), 32'(MemAsid));
      reset = 1'b0;
      @(negedge clk);
      #1;
      chk("post-rst op_ready", 32'(op_ready), 32'd1);
      chk("post-rst results", {26'd0, res_found, res_ne, res_index}, 32'd0);
      chk("post-rst outputs", {22'd0, w_index, r_index, w_e, op_err}, 32'd0);

      for (int i = 0; i < 11; i++) do_op(vecs[i], i);

      // Request raised while busy (now in DONE) and held: accepted exactly once.
      op_valid = 1'b1; op_code = 3'd2; csr_index = 4'd9; csr_ne = 1'b0; csr_vppn = 19'h00909;
      m_wvppn = 19'h00909;
      chk("held not ready", 32'(op_ready), 32'd0);
      @(negedge clk);
      #1;
      chk("held accept ready", 32'(op_ready), 32'd1);
      @(negedge clk);
      op_valid = 1'b0;
      #1;
      chk("held exec we", 32'(we), 32'd1);
      chk("held exec w_index", 32'(w_index), 32'd9);
      wcount = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         if (we) wcount++;
      end
      chk("held single write", 32'(wcount), 32'd0);

      // Reset during EXEC of a WR.
      @(negedge clk);
      wait_ready();
      op_valid = 1'b1; op_code = 3'd2; csr_index = 4'd7; csr_ne = 1'b0; mem_req = 1'b1;
      @(negedge clk);
      op_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("rst-exec we", 32'(we), 32'd0);
      chk("rst-exec ready/done", {30'd0, op_ready, done}, 32'd0);
      @(negedge clk);
      #1;
      chk("rst-exec no done", 32'(done), 32'd0);
      chk("rst-exec held ready low", 32'(op_ready), 32'd0);
      reset = 1'b0;
      fill_cnt = '0;
      @(negedge clk);
      #1;
      chk("rst-exec ready after", 32'(op_ready), 32'd1);
      chk("rst-exec done after", 32'(done), 32'd0);
      chk("rst-exec res cleared", {26'd0, res_found, res_ne, res_index}, 32'd0);

      // 17 consecutive FILLs: 0..15 then 0 in the default build.
      fv = vecs[10];
      for (int k = 0; k < 17; k++) begin
         fv.vppn = 19'h10000 + 19'(k);
         do_op(fv, 100 + k);
      end
`ifndef TLB_FILL_LFSR_EN
      chk("fill wrap count", 32'(fill_cnt), 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Sequences the TLB maintenance instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) issued by the pipeline onto the `tlb` block's ports. It sits between the WB-stage instruction/CSR logic and `tlb`, and owns the fill-index policy. It also arbitrates search port 1 between the load/store path and TLBSRCH/INVTLB, which both reuse that port's `s1_vppn`/`s1_asid`.

## Interface
Parameters:
- `TLBNUM`, 16: TLB entry count (power of two, 2–256); `IW = $clog2(TLBNUM)`.

Ports (one clock `clk`; reset `reset` is synchronous and active-high):
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `op_valid`  in  1  TLB instruction request
- `op_ready`  out  1  controller can accept
- `op_code`  in  3  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV, 5–7 illegal
- `inv_op`  in  5  INVTLB op field
- `inv_asid`  in  10  INVTLB rj[9:0]
- `inv_vppn`  in  19  INVTLB rk[31:13]
- `csr_asid`  in  10  ASID.ASID
- `csr_vppn`  in  19  TLBEHI.VPPN
- `csr_index`  in  IW  TLBIDX.Index
- `csr_ne`  in  1  TLBIDX.NE
- `mem_vppn`  in  19  load/store lookup VPPN
- `mem_asid`  in  10  load/store lookup ASID
- `mem_req`  in  1  load/store needs port 1 this cycle
- `mem_stall`  out  1  port 1 taken; load/store must hold
- `s1_vppn`  out  19  to `tlb` port 1
- `s1_asid`  out  10  to `tlb` port 1
- `s1_found`  in  1  from `tlb`
- `s1_index`  in  IW  from `tlb`
- `r_index`  out  IW  to `tlb` read port
- `r_e`  in  1  from `tlb`
- `we`  out  1  to `tlb`
- `w_index`  out  IW  to `tlb`
- `w_e`  out  1  to `tlb`
- `invtlb_valid`  out  1  to `tlb`
- `invtlb_op`  out  5  to `tlb`
- `done`  out  1  one-cycle completion pulse
- `op_err`  out  1  with `done`: illegal op_code or inv_op > 6 (INE)
- `res_found`  out  1  SRCH hit, held until next SRCH
- `res_index`  out  IW  SRCH hit index, held until next SRCH
- `res_ne`  out  1  RD: `~r_e`, held until next RD

## Operation
- FSM states: IDLE, EXEC, DONE. Transitions: IDLE→EXEC on `op_valid && op_ready`; EXEC→DONE always; DONE→IDLE always.
- `op_ready` = 1 only in IDLE. `op_code`, `inv_*` and `csr_*` are latched at accept; later changes to them are ignored.
- EXEC actions by op:
  - SRCH: drive `s1_vppn=csr_vppn`, `s1_asid=csr_asid`; capture `s1_found`→`res_found` and `s1_index`→`res_index` (index captured even on miss).
  - RD: drive `r_index=csr_index`; capture `res_ne = ~r_e`.
  - WR: `we=1`, `w_index=csr_index`, `w_e=~csr_ne`.
  - FILL: `we=1`, `w_index=fill_idx`, `w_e=~csr_ne`. The fill pointer then advances.
  - INV with `inv_op ≤ 6`: `invtlb_valid=1`, `invtlb_op=inv_op`, `s1_vppn=inv_vppn`, `s1_asid=inv_asid`.
  - INV with `inv_op > 6`, or `op_code` 5–7: no TLB action; `op_err=1` in DONE.
- Port-1 mux: outside EXEC-SRCH and EXEC-INV, `s1_* = mem_*`. `mem_stall = mem_req && (state==EXEC) && (op is SRCH or INV)`.
- `we` and `invtlb_valid` are never high in the same cycle. Each fires exactly once per op.
- Fill pointer, default: counter `fill_idx`, reset 0, +1 per FILL, wraps TLBNUM-1→0.

## Timing
- Accept at cycle T. EXEC at T+1, when all TLB-side strobes fire. DONE at T+2 (`done=1`, results valid). IDLE again at T+3.
- Throughput: one op per 3 cycles.
- SRCH result uses the combinational `s1_*` of `tlb` in the same EXEC cycle. RD uses `r_*` the same way.
- A WR/FILL write lands at the T+1 clock edge. A following SRCH cannot be in EXEC before T+4, so it sees the new entry.
- Reset values: state IDLE; `op_ready`=0 during reset and 1 after; `done`, `op_err`, `we`, `invtlb_valid`, `mem_stall`, `res_found`, `res_ne`=0; `res_index`, `r_index`, `w_index`, `invtlb_op`=0; `w_e`=0; `s1_*` follow `mem_*`.
- Reset mid-operation: reset wins in the same cycle. No `we`/`invtlb_valid` is asserted while `reset`=1, and no `done` is issued for the aborted op. TLB contents are not cleared.
- `op_valid` while not ready: held by the requester; no loss and no duplication.

## Configuration
- `TLB_FILL_LFSR_EN` defined:
  - `fill_idx = lfsr[IW-1:0]`.
  - `lfsr` is 8-bit Fibonacci, taps 8,6,5,4, reset 8'h01, advancing every non-reset cycle (pseudo-random replacement).
- Undefined: round-robin counter as in Operation. No other behaviour changes.

## Test plan
- WR `csr_index=5`, `csr_ne=0`, then SRCH with matching `csr_vppn`/`csr_asid` → `we` pulse at T+1 with `w_index=5`, `w_e=1`; SRCH DONE gives `res_found=1`, `res_index=5`.
- RD `csr_index=3` after a write to entry 3 with `csr_ne=1` → `res_ne=1`, `done` at T+2.
- 17 consecutive FILLs, default build → `w_index` sequence 0..15, then 0. With `TLB_FILL_LFSR_EN` → sequence matches the reference LFSR model.
- INV `inv_op=5` with `mem_req=1` held → `invtlb_valid=1`, `invtlb_op=5`, `s1_vppn=inv_vppn`, `mem_stall=1` for exactly one cycle. INV `inv_op=9` → no strobe, `done=1` with `op_err=1`.
- `reset` asserted during EXEC of a WR → `we`=0 that cycle, no `done`, state IDLE, `op_ready`=1 the cycle after reset drops.
